// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: I-cache lookup per PC, byte-wide bus refill on a miss, single-entry IF/ID output.
// Hit/miss counters are built only when IF_PERF_CNT_EN is defined; otherwise both count outputs read 0.
module inst_fetch_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              pc_valid_i,
   output logic              pc_ack_o,
   output logic [ADDR_W-1:0] cache_read_addr_o,
   input  logic              cache_hit_i,
   input  logic [31:0]       cache_inst_i,
   output logic              cache_we_o,
   output logic [ADDR_W-1:0] cache_write_addr_o,
   output logic [31:0]       cache_write_inst_o,
   output logic              mem_req_o,
   input  logic              mem_grant_i,
   output logic [ADDR_W-1:0] mem_a_o,
   input  logic [7:0]        mem_din_i,
   output logic              if_valid_o,
   input  logic              if_ready_i,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [31:0]       if_inst_o,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
);
   typedef enum logic [1:0] {IDLE, WAIT_GNT, FETCH, FILL} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        cnt_reg, cnt_next;
   logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
   logic [31:0]       word_reg, word_next;
   logic [ADDR_W-1:0] mem_a_reg, mem_a_next;
   logic              if_valid_reg, if_valid_next;
   logic [ADDR_W-1:0] if_pc_reg, if_pc_next;
   logic [31:0]       if_inst_reg, if_inst_next;
   logic              slot_free;
   logic [1:0]        byte_sel;
   logic              hit_evt, fill_evt;

   assign slot_free          = !if_valid_reg || if_ready_i;
   // Byte returned this cycle belongs to the address presented one cycle earlier.
   assign byte_sel           = 2'(cnt_reg - 3'd1);
   assign cache_read_addr_o  = pc_i;
   assign cache_write_addr_o = fetch_pc_reg;
   assign cache_write_inst_o = word_reg;
   assign mem_a_o            = mem_a_reg;
   assign if_valid_o         = if_valid_reg;
   assign if_pc_o            = if_pc_reg;
   assign if_inst_o          = if_inst_reg;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      fetch_pc_next = fetch_pc_reg;
      word_next     = word_reg;
      mem_a_next    = mem_a_reg;
      if_valid_next = if_valid_reg;
      if_pc_next    = if_pc_reg;
      if_inst_next  = if_inst_reg;
      pc_ack_o      = 1'b0;
      cache_we_o    = 1'b0;
      mem_req_o     = 1'b0;
      hit_evt       = 1'b0;
      fill_evt      = 1'b0;

      if (if_valid_reg && if_ready_i)
         if_valid_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (pc_valid_i && slot_free && !flush_i) begin
               pc_ack_o = 1'b1;
               if (cache_hit_i) begin
                  if_valid_next = 1'b1;
                  if_pc_next    = pc_i;
                  if_inst_next  = cache_inst_i;
                  hit_evt       = 1'b1;
               end else begin
                  fetch_pc_next = pc_i;
                  state_next    = WAIT_GNT;
               end
            end
         end
         WAIT_GNT: begin
            mem_req_o = 1'b1;
            if (mem_grant_i) begin
               state_next = FETCH;
               cnt_next   = 3'd0;
               mem_a_next = fetch_pc_reg;
            end
         end
         FETCH: begin
            mem_req_o = 1'b1;
            if (cnt_reg != 3'd0)
               word_next[{byte_sel, 3'b000} +: 8] = mem_din_i;
            if (cnt_reg < 3'd3)
               mem_a_next = fetch_pc_reg + ADDR_W'(cnt_reg + 3'd1);
            if (cnt_reg == 3'd4)
               state_next = FILL;
            else
               cnt_next = cnt_reg + 3'd1;
         end
         FILL: begin
            // Slot was free at miss accept and nothing has issued since, so the load is unconditional.
            if (!flush_i) begin
               cache_we_o    = 1'b1;
               if_valid_next = 1'b1;
               if_pc_next    = fetch_pc_reg;
               if_inst_next  = word_reg;
               fill_evt      = 1'b1;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (flush_i) begin
         if_valid_next = 1'b0;
         state_next    = IDLE;
      end

      if (rst || !rdy) begin
         pc_ack_o   = 1'b0;
         cache_we_o = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= 3'd0;
         fetch_pc_reg <= '0;
         word_reg     <= '0;
         mem_a_reg    <= '0;
         if_valid_reg <= 1'b0;
         if_pc_reg    <= '0;
         if_inst_reg  <= '0;
      end else if (rdy) begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         fetch_pc_reg <= fetch_pc_next;
         word_reg     <= word_next;
         mem_a_reg    <= mem_a_next;
         if_valid_reg <= if_valid_next;
         if_pc_reg    <= if_pc_next;
         if_inst_reg  <= if_inst_next;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] hit_cnt_reg, miss_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_reg  <= '0;
         miss_cnt_reg <= '0;
      end else if (rdy) begin
         if (hit_evt)
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
         if (fill_evt)
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_reg;
   assign miss_cnt_o = miss_cnt_reg;
`else
   logic unused_evt;
   assign unused_evt = hit_evt ^ fill_evt;
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios, then random traffic checked against a byte-memory,
// cache and in-order issue model. Counter expectations follow IF_PERF_CNT_EN.
module tb_inst_fetch_unit;
   logic        clk = 1'b0;
   logic        rst, rdy, flush_i, pc_valid_i, pc_ack_o, cache_hit_i, cache_we_o;
   logic        mem_req_o, mem_grant_i, if_valid_o, if_ready_i;
   logic [31:0] pc_i, cache_read_addr_o, cache_inst_i, cache_write_addr_o, cache_write_inst_o;
   logic [31:0] mem_a_o, if_pc_o, if_inst_o, hit_cnt_o, miss_cnt_o;
   logic [7:0]  mem_din_i;

   logic [7:0]  mem_m   [logic [31:0]];
   logic [31:0] cache_m [logic [31:0]];
   logic [31:0] exp_q[$];
   logic [31:0] prev_a = 32'd0;
   logic [31:0] a_hold;
   logic [31:0] pool [8];
   bit          gnt_auto = 1'b0;
   bit          drained;
   int          n_cmp = 0;
   int          n_err = 0;

   inst_fetch_unit #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i),
      .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ack_o(pc_ack_o),
      .cache_read_addr_o(cache_read_addr_o), .cache_hit_i(cache_hit_i), .cache_inst_i(cache_inst_i),
      .cache_we_o(cache_we_o), .cache_write_addr_o(cache_write_addr_o), .cache_write_inst_o(cache_write_inst_o),
      .mem_req_o(mem_req_o), .mem_grant_i(mem_grant_i), .mem_a_o(mem_a_o), .mem_din_i(mem_din_i),
      .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] get_byte(input logic [31:0] a);
      if (!mem_m.exists(a))
         mem_m[a] = 8'($urandom);
      return mem_m[a];
   endfunction

   // Little-endian word starting at byte address a, wrapping at 2^32.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {get_byte(a + 32'd3), get_byte(a + 32'd2), get_byte(a + 32'd1), get_byte(a)};
   endfunction

   task automatic refresh_cache();
      if (cache_m.exists(pc_i)) begin
         cache_hit_i  = 1'b1;
         cache_inst_i = cache_m[pc_i];
      end else begin
         cache_hit_i  = 1'b0;
         cache_inst_i = $urandom;
      end
   endtask

   task automatic set_pc(input logic v, input logic [31:0] a);
      pc_valid_i = v;
      pc_i       = a;
      refresh_cache();
   endtask

   // One clock: score the cycle's handshakes, advance, then update memory/cache/arbiter models.
   task automatic tick();
      logic        we;
      logic [31:0] wa, wi;
      #1;
      we = 1'b0;
      wa = '0;
      wi = '0;
      if (rst) begin
         exp_q.delete();
      end else if (rdy) begin
         if (if_valid_o && if_ready_i) begin
            check("issue_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               check("issue_pc", if_pc_o, exp_q[0]);
               check("issue_inst", if_inst_o, mem_word(exp_q[0]));
               void'(exp_q.pop_front());
            end
         end
         if (cache_we_o) begin
            check("fill_inst", cache_write_inst_o, mem_word(cache_write_addr_o));
            we = 1'b1;
            wa = cache_write_addr_o;
            wi = cache_write_inst_o;
         end
         if (flush_i)
            exp_q.delete();
         if (pc_ack_o)
            exp_q.push_back(pc_i);
         prev_a = mem_a_o;
      end
      @(posedge clk);
      #1;
      mem_din_i = get_byte(prev_a);
      if (we)
         cache_m[wa] = wi;
      refresh_cache();
      if (gnt_auto)
         mem_grant_i = mem_req_o ? (mem_grant_i | ($urandom_range(0, 2) == 0)) : 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; flush_i = 1'b0; mem_grant_i = 1'b0; if_ready_i = 1'b1;
      mem_din_i = 8'd0;
      set_pc(1'b1, 32'h0);
      tick(); tick();
      #1;
      check("rst_ack", pc_ack_o, 0);
      check("rst_valid", if_valid_o, 0);
      check("rst_req", mem_req_o, 0);
      check("rst_we", cache_we_o, 0);
      check("rst_pc", if_pc_o, 0);
      check("rst_inst", if_inst_o, 0);
      check("rst_mem_a", mem_a_o, 0);
      check("rst_hits", hit_cnt_o, 0);
      check("rst_misses", miss_cnt_o, 0);
      set_pc(1'b0, 32'h0);
      rst = 1'b0;
      tick();

      // Miss at 0x0 with grant held high.
      mem_m[32'h0] = 8'h13; mem_m[32'h1] = 8'h05; mem_m[32'h2] = 8'h10; mem_m[32'h3] = 8'h00;
      mem_grant_i = 1'b1;
      set_pc(1'b1, 32'h0);
      #1;
      check("t1_ack", pc_ack_o, 1);
      check("t1_rd_addr", cache_read_addr_o, pc_i);
      tick();
      set_pc(1'b0, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         check("t1_req", mem_req_o, 32'(k <= 6));
         if (k >= 2 && k <= 5)
            check("t1_mem_a", mem_a_o, 32'(k - 2));
         if (k == 7) begin
            check("t1_we", cache_we_o, 1);
            check("t1_we_addr", cache_write_addr_o, 32'h0);
            check("t1_we_inst", cache_write_inst_o, 32'h00100513);
            check("t1_early_valid", if_valid_o, 0);
         end
         if (k == 8) begin
            check("t1_valid", if_valid_o, 1);
            check("t1_pc", if_pc_o, 32'h0);
            check("t1_inst", if_inst_o, 32'h00100513);
         end
         if (k < 8)
            tick();
      end

      // Back-to-back hits.
      for (int i = 1; i <= 4; i++)
         cache_m[32'(4 * i)] = mem_word(32'(4 * i));
      for (int i = 0; i < 3; i++) begin
         set_pc(1'b1, 32'(4 + 4 * i));
         #1;
         check("t2_ack", pc_ack_o, 1);
         check("t2_valid", if_valid_o, 1);
         if (i > 0)
            check("t2_pc", if_pc_o, 32'(4 * i));
         tick();
      end
      set_pc(1'b0, 32'h0);
      check("t2_last_pc", if_pc_o, 32'hC);
      check("t2_last_inst", if_inst_o, mem_word(32'hC));

      // Downstream stall holds the word and blocks new accepts.
      if_ready_i = 1'b0;
      set_pc(1'b1, 32'h10);
      for (int j = 0; j < 3; j++) begin
         #1;
         check("t3_no_ack", pc_ack_o, 0);
         check("t3_hold_inst", if_inst_o, mem_word(32'hC));
         tick();
      end
      if_ready_i = 1'b1;
      #1;
      check("t3_ack", pc_ack_o, 1);
      tick();
      set_pc(1'b0, 32'h0);
      check("t3_pc", if_pc_o, 32'h10);

      // Miss with grant delayed five cycles.
      mem_grant_i = 1'b0;
      a_hold = mem_a_o;
      set_pc(1'b1, 32'h100);
      #1;
      check("t4_ack", pc_ack_o, 1);
      tick();
      set_pc(1'b0, 32'h0);
      for (int k = 1; k <= 13; k++) begin
         check("t4_req", mem_req_o, 32'(k <= 11));
         if (k <= 6)
            check("t4_mem_a_idle", mem_a_o, a_hold);
         if (k == 7)
            check("t4_mem_a", mem_a_o, 32'h100);
         if (k == 12) begin
            check("t4_early_valid", if_valid_o, 0);
            check("t4_we_addr", cache_write_addr_o, 32'h100);
         end
         if (k == 13) begin
            check("t4_valid", if_valid_o, 1);
            check("t4_pc", if_pc_o, 32'h100);
         end
         if (k == 6)
            mem_grant_i = 1'b1;
         if (k < 13)
            tick();
      end

      // Flush at FETCH cnt=2.
      set_pc(1'b1, 32'h200);
      #1;
      check("t5_ack", pc_ack_o, 1);
      tick();
      set_pc(1'b0, 32'h0);
      tick(); tick(); tick();
      check("t5_mem_a", mem_a_o, 32'h202);
      flush_i = 1'b1;
      #1;
      check("t5_flush_we", cache_we_o, 0);
      tick();
      flush_i = 1'b0;
      for (int j = 0; j < 6; j++) begin
         check("t5_req", mem_req_o, 0);
         check("t5_valid", if_valid_o, 0);
         check("t5_we", cache_we_o, 0);
         tick();
      end

      // rdy low for four cycles mid-FETCH.
      set_pc(1'b1, 32'h300);
      #1;
      check("t6_ack", pc_ack_o, 1);
      tick();
      set_pc(1'b0, 32'h0);
      tick(); tick();
      check("t6_mem_a", mem_a_o, 32'h301);
      rdy = 1'b0;
      for (int j = 0; j < 4; j++) begin
         #1;
         check("t6_frozen_a", mem_a_o, 32'h301);
         check("t6_frozen_req", mem_req_o, 1);
         tick();
      end
      rdy = 1'b1;
      check("t6_resume_a", mem_a_o, 32'h301);
      for (int k = 7; k <= 12; k++) begin
         if (k == 11) begin
            check("t6_we", cache_we_o, 1);
            check("t6_we_inst", cache_write_inst_o, mem_word(32'h300));
         end
         if (k == 12) begin
            check("t6_valid", if_valid_o, 1);
            check("t6_inst", if_inst_o, mem_word(32'h300));
         end
         if (k < 12)
            tick();
      end
`ifdef IF_PERF_CNT_EN
      check("perf_hits", hit_cnt_o, 32'd4);
      check("perf_misses", miss_cnt_o, 32'd3);
`else
      check("perf_hits", hit_cnt_o, 32'd0);
      check("perf_misses", miss_cnt_o, 32'd0);
`endif

      // Reset in the middle of a fetch releases the bus.
      set_pc(1'b1, 32'h500);
      tick();
      set_pc(1'b0, 32'h0);
      tick(); tick();
      check("t7_req_before", mem_req_o, 1);
      rst = 1'b1;
      tick();
      check("t7_req", mem_req_o, 0);
      check("t7_mem_a", mem_a_o, 0);
      check("t7_valid", if_valid_o, 0);
      check("t7_hits", hit_cnt_o, 0);
      rst = 1'b0;
      tick();

      // Random traffic, including a fetch that wraps past the top of the address space.
      pool = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h800, 32'h1000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFE};
      mem_grant_i = 1'b0;
      gnt_auto = 1'b1;
      for (int n = 0; n < 500; n++) begin
         logic [31:0] a;
         rdy        = ($urandom_range(0, 9) != 0);
         flush_i    = ($urandom_range(0, 24) == 0);
         if_ready_i = ($urandom_range(0, 3) != 0);
         a = pool[$urandom_range(0, 7)];
         if ($urandom_range(0, 7) == 0)
            cache_m.delete(a);
         set_pc($urandom_range(0, 3) != 0, a);
         tick();
      end
      rdy = 1'b1; flush_i = 1'b0; if_ready_i = 1'b1;
      set_pc(1'b0, 32'h0);
      drained = 1'b0;
      for (int n = 0; n < 80 && !drained; n++) begin
         tick();
         drained = (exp_q.size() == 0) && !mem_req_o && !if_valid_o;
      end
      check("drain", 32'(drained), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
